// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and helpers for the UART receive/transmit blocks
//
// Contents:
//   rx_state_e   receiver frame state
//   TICK_DIV_MIN smallest legal oversample tick divider
//   tick_div()   clocks per oversample tick, integer-truncated
//   maj3()       2-of-3 majority vote
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_e;

    localparam int TICK_DIV_MIN = 2;

    function automatic int tick_div(input int clkf, input int baud, input int osr);
        return clkf / (baud * osr);
    endfunction

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - oversample tick divider with synchronous restart
//
// Ports:
//   clk, rstn  clock, synchronous active-low reset
//   restart    forces the divider back to count 0 (no tick on that cycle)
//   tick       one-cycle pulse every DIV clocks
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int DIV = 10
) (
    input  logic clk,
    input  logic rstn,
    input  logic restart,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

    if (DIV < TICK_DIV_MIN) begin : g_div_check
        $error("uart_baud_tick: divider %0d is below minimum %0d", DIV, TICK_DIV_MIN);
    end

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt <= '0;
        end else if (restart || cnt == CNT_LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == CNT_LAST) && !restart;

endmodule

// File: rtl/uart_rx_os.sv
// rtl/uart_rx_os.sv - oversampling UART receiver with 3-sample majority vote
//
// Optional feature macro: UART_RX_PARITY_EN (adds a parity bit after the data bits).
//
// Ports:
//   clk, rstn   clock, synchronous active-low reset
//   i_rxs       asynchronous serial line, idles high
//   o_rvalid    holding register contains a word
//   i_rready    consumer accepts the word when o_rvalid && i_rready
//   o_rdata     received word, bit 0 first on the line
//   o_ferr      framing error of the held word
//   o_perr      parity error of the held word (0 without parity)
//   o_overrun   one-cycle pulse when a completed frame is dropped
module uart_rx_os
    import uart_pkg::*;
#(
    parameter int CLKF       = 100000000,
    parameter int BAUD       = 115200,
    parameter int OSR        = 16,
    parameter int DLEN       = 8,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            i_rxs,
    output logic            o_rvalid,
    input  logic            i_rready,
    output logic [DLEN-1:0] o_rdata,
    output logic            o_ferr,
    output logic            o_perr,
    output logic            o_overrun
);

    localparam int TICK_DIV = tick_div(CLKF, BAUD, OSR);
    localparam int SCT_W    = $clog2(OSR);
    localparam int BIT_W    = $clog2(DLEN);

    localparam logic [SCT_W-1:0] SCT_S0   = SCT_W'(OSR / 2 - 1);
    localparam logic [SCT_W-1:0] SCT_S1   = SCT_W'(OSR / 2);
    localparam logic [SCT_W-1:0] SCT_VOTE = SCT_W'(OSR / 2 + 1);
    localparam logic [SCT_W-1:0] SCT_LAST = SCT_W'(OSR - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DLEN - 1);
    localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

    if (OSR != 8 && OSR != 16) begin : g_osr_check
        $error("uart_rx_os: OSR must be 8 or 16");
    end
    if (DLEN < 5 || DLEN > 9) begin : g_dlen_check
        $error("uart_rx_os: DLEN must be 5..9");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_stop_check
        $error("uart_rx_os: STOP_BITS must be 1 or 2");
    end

    logic             sync0;
    logic             rxs_s;
    logic             rxs_q;
    rx_state_e        state;
    logic [SCT_W-1:0] sct;
    logic [BIT_W-1:0] bit_idx;
    logic             stop_idx;
    logic             smp_a;
    logic             smp_b;
    logic [DLEN-1:0]  shreg;
    logic             ferr_acc;
    logic             tick;
    logic             fall;
    logic             restart;
    logic             vote;
    logic             vote_now;
    logic             wrap;

    assign fall     = rxs_q & ~rxs_s;
    assign restart  = (state == IDLE) && fall;
    // The third sample is the live line value on the deciding tick.
    assign vote     = maj3(smp_a, smp_b, rxs_s);
    assign vote_now = tick && (sct == SCT_VOTE);
    assign wrap     = tick && (sct == SCT_LAST);

    uart_baud_tick #(
        .DIV (TICK_DIV)
    ) u_tick (
        .clk     (clk),
        .rstn    (rstn),
        .restart (restart),
        .tick    (tick)
    );

`ifdef UART_RX_PARITY_EN
    logic par_bit;
    logic perr_q;
    assign o_perr = perr_q;
`else
    assign o_perr = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rstn) begin
            sync0     <= 1'b1;
            rxs_s     <= 1'b1;
            rxs_q     <= 1'b1;
            state     <= IDLE;
            sct       <= '0;
            bit_idx   <= '0;
            stop_idx  <= 1'b0;
            smp_a     <= 1'b1;
            smp_b     <= 1'b1;
            shreg     <= '0;
            ferr_acc  <= 1'b0;
            o_rvalid  <= 1'b0;
            o_rdata   <= '0;
            o_ferr    <= 1'b0;
            o_overrun <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit   <= 1'b0;
            perr_q    <= 1'b0;
`endif
        end else begin
            sync0     <= i_rxs;
            rxs_s     <= sync0;
            rxs_q     <= rxs_s;
            o_overrun <= 1'b0;

            // Handshake clear; a commit later in this block overrides it.
            if (o_rvalid && i_rready) begin
                o_rvalid <= 1'b0;
            end

            if (tick && state != IDLE) begin
                if (sct == SCT_S0) smp_a <= rxs_s;
                if (sct == SCT_S1) smp_b <= rxs_s;
                sct <= (sct == SCT_LAST) ? '0 : sct + 1'b1;
            end

            case (state)
                IDLE: begin
                    if (fall) begin
                        state    <= START;
                        sct      <= '0;
                        bit_idx  <= '0;
                        stop_idx <= 1'b0;
                        ferr_acc <= 1'b0;
                    end
                end
                START: begin
                    if (vote_now && vote) begin
                        state <= IDLE;
                    end else if (wrap) begin
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (vote_now) begin
                        shreg <= {vote, shreg[DLEN-1:1]};
                    end
                    if (wrap) begin
                        if (bit_idx == BIT_LAST) begin
                            bit_idx <= '0;
`ifdef UART_RX_PARITY_EN
                            state   <= PARITY;
`else
                            state   <= STOP;
`endif
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (vote_now) begin
                        par_bit <= vote;
                    end
                    if (wrap) begin
                        state <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (vote_now) begin
                        if (stop_idx == STOP_LAST) begin
                            // Leave early so the next start edge is seen half a bit sooner.
                            state <= IDLE;
                            if (o_rvalid && !i_rready) begin
                                o_overrun <= 1'b1;
                            end else begin
                                o_rvalid <= 1'b1;
                                o_rdata  <= shreg;
                                o_ferr   <= ferr_acc | ~vote;
`ifdef UART_RX_PARITY_EN
                                perr_q   <= par_bit ^ (^shreg) ^ 1'(PARITY_ODD);
`endif
                            end
                        end else begin
                            ferr_acc <= ferr_acc | ~vote;
                            stop_idx <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_os.sv
// tb/tb_uart_rx_os.sv - directed table-driven bench for uart_rx_os
module tb_uart_rx_os;

`ifdef UART_RX_PARITY_EN
    localparam int DLEN = 7;
`else
    localparam int DLEN = 8;
`endif
    localparam int BIT_CLKS = 160;

    logic            clk = 1'b0;
    logic            rstn;
    logic            i_rxs;
    logic            i_rready;
    logic            o_rvalid;
    logic [DLEN-1:0] o_rdata;
    logic            o_ferr;
    logic            o_perr;
    logic            o_overrun;

    always #5 clk = ~clk;

    uart_rx_os #(
        .CLKF       (100000000),
        .BAUD       (625000),
        .OSR        (16),
        .DLEN       (DLEN),
        .STOP_BITS  (1),
        .PARITY_ODD (0)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .i_rxs     (i_rxs),
        .o_rvalid  (o_rvalid),
        .i_rready  (i_rready),
        .o_rdata   (o_rdata),
        .o_ferr    (o_ferr),
        .o_perr    (o_perr),
        .o_overrun (o_overrun)
    );

    typedef struct {
        logic [DLEN-1:0] data;
        bit              stop_low;
        bit              par_flip;
        logic [DLEN-1:0] exp_data;
        bit              exp_ferr;
        bit              exp_perr;
    } vec_t;

    vec_t vecs[$];

    int tests = 0;
    int fails = 0;

    int              cap_cnt = 0;
    int              ovr_cnt = 0;
    logic [DLEN-1:0] last_data;
    logic            last_ferr;
    logic            last_perr;

    always @(negedge clk) begin
        if (o_rvalid && i_rready) begin
            cap_cnt   = cap_cnt + 1;
            last_data = o_rdata;
            last_ferr = o_ferr;
            last_perr = o_perr;
        end
        if (o_overrun) ovr_cnt = ovr_cnt + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic v, input bit glitch);
        i_rxs = v;
        if (glitch) begin
            step(85);
            i_rxs = ~v;
            step(10);
            i_rxs = v;
            step(BIT_CLKS - 95);
        end else begin
            step(BIT_CLKS);
        end
    endtask

    task automatic send_frame(input logic [DLEN-1:0] d, input bit stop_low,
                              input bit par_flip, input bit glitch);
        send_bit(1'b0, glitch);
        for (int i = 0; i < DLEN; i++) send_bit(d[i], glitch);
`ifdef UART_RX_PARITY_EN
        send_bit((^d) ^ par_flip, glitch);
`else
        if (par_flip) i_rxs = 1'b1;
`endif
        send_bit(!stop_low, glitch);
        i_rxs = 1'b1;
    endtask

    int base_cap;
    int base_ovr;

    initial begin
        vecs.push_back('{DLEN'(8'hA5), 1'b0, 1'b0, DLEN'(8'hA5), 1'b0, 1'b0});
        vecs.push_back('{DLEN'(8'h55), 1'b0, 1'b0, DLEN'(8'h55), 1'b0, 1'b0});
        vecs.push_back('{DLEN'(8'h00), 1'b0, 1'b0, DLEN'(8'h00), 1'b0, 1'b0});
        vecs.push_back('{DLEN'(8'hFF), 1'b0, 1'b0, DLEN'(8'hFF), 1'b0, 1'b0});
        vecs.push_back('{DLEN'(8'h0F), 1'b1, 1'b0, DLEN'(8'h0F), 1'b1, 1'b0});
        vecs.push_back('{DLEN'(8'h10), 1'b0, 1'b0, DLEN'(8'h10), 1'b0, 1'b0});
`ifdef UART_RX_PARITY_EN
        vecs.push_back('{DLEN'(8'h41), 1'b0, 1'b0, DLEN'(8'h41), 1'b0, 1'b0});
        vecs.push_back('{DLEN'(8'h41), 1'b0, 1'b1, DLEN'(8'h41), 1'b0, 1'b1});
`endif

        // Reset state
        rstn     = 1'b0;
        i_rxs    = 1'b1;
        i_rready = 1'b1;
        step(5);
        check("reset_rvalid", o_rvalid, 0);
        check("reset_rdata", o_rdata, 0);
        check("reset_ferr", o_ferr, 0);
        check("reset_perr", o_perr, 0);
        check("reset_overrun", o_overrun, 0);
        rstn = 1'b1;
        step(20);

        // Table-driven single frames with the consumer always ready
        foreach (vecs[k]) begin
            base_cap = cap_cnt;
            base_ovr = ovr_cnt;
            send_frame(vecs[k].data, vecs[k].stop_low, vecs[k].par_flip, 1'b0);
            step(20);
            check($sformatf("vec%0d_count", k), cap_cnt - base_cap, 1);
            check($sformatf("vec%0d_data", k), last_data, vecs[k].exp_data);
            check($sformatf("vec%0d_ferr", k), last_ferr, vecs[k].exp_ferr);
            check($sformatf("vec%0d_perr", k), last_perr, vecs[k].exp_perr);
            check($sformatf("vec%0d_overrun", k), ovr_cnt - base_ovr, 0);
        end

        // Back-pressure: second frame is dropped with a single overrun pulse
        i_rready = 1'b0;
        base_cap = cap_cnt;
        base_ovr = ovr_cnt;
        send_frame(DLEN'(8'h3C), 1'b0, 1'b0, 1'b0);
        send_frame(DLEN'(8'hC3), 1'b0, 1'b0, 1'b0);
        step(20);
        check("bp_rvalid", o_rvalid, 1);
        check("bp_rdata", o_rdata, DLEN'(8'h3C));
        check("bp_overrun", ovr_cnt - base_ovr, 1);
        i_rready = 1'b1;
        step(1);
        check("bp_rvalid_cleared", o_rvalid, 0);
        check("bp_accept_count", cap_cnt - base_cap, 1);

        // False start: 40-clock glitch, then a normal frame
        step(20);
        base_cap = cap_cnt;
        i_rxs = 1'b0;
        step(40);
        i_rxs = 1'b1;
        step(400);
        check("false_start_count", cap_cnt - base_cap, 0);
        check("false_start_rvalid", o_rvalid, 0);
        send_frame(DLEN'(8'h55), 1'b0, 1'b0, 1'b0);
        step(20);
        check("after_false_count", cap_cnt - base_cap, 1);
        check("after_false_data", last_data, DLEN'(8'h55));

        // Mid-frame reset with a word held
        i_rready = 1'b0;
        send_frame(DLEN'(8'h66), 1'b0, 1'b0, 1'b0);
        step(20);
        check("held_before_reset", o_rvalid, 1);
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b0, 1'b0);
        i_rxs = 1'b1;
        step(80);
        rstn = 1'b0;
        step(3);
        check("midrst_rvalid", o_rvalid, 0);
        check("midrst_rdata", o_rdata, 0);
        check("midrst_ferr", o_ferr, 0);
        check("midrst_overrun", o_overrun, 0);
        rstn     = 1'b1;
        i_rready = 1'b1;
        base_cap = cap_cnt;
        base_ovr = ovr_cnt;
        step(5 * BIT_CLKS);
        check("midrst_no_word", cap_cnt - base_cap, 0);
        check("midrst_no_overrun", ovr_cnt - base_ovr, 0);

        // Noise rejection: one inverted sample at every bit centre
        send_frame(DLEN'(8'h81), 1'b0, 1'b0, 1'b1);
        step(20);
        check("glitch_count", cap_cnt - base_cap, 1);
        check("glitch_data", last_data, DLEN'(8'h81));
        check("glitch_ferr", last_ferr, 0);
        check("glitch_perr", last_perr, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_rx_os.md
# uart_rx_os

Parametrised, oversampling UART receiver for the serial I/O subsystem. It replaces the fixed single-sample receiver in new designs. The receiver synchronises the asynchronous line and takes a 3-sample majority vote at each bit centre. It supports 5–9 data bits, 1 or 2 stop bits and optional parity. Received words are delivered over a valid/ready interface with framing, parity and overrun flags, so a FIFO or bus bridge can sit directly downstream.

## Interface
- `CLKF`, 100000000, clock frequency in Hz.
- `BAUD`, 115200, line rate in bit/s.
- `OSR`, 16, oversampling ratio; legal values are 8 or 16.
- `DLEN`, 8, data bits per frame; legal range 5..9.
- `STOP_BITS`, 1, stop bits per frame; legal values 1 or 2.
- `PARITY_ODD`, 0, parity sense: 0 = even, 1 = odd. Used only when `UART_RX_PARITY_EN` is defined.

Ports:
- `clk` in 1: clock.
- `rstn` in 1: reset, synchronous, active-low.
- `i_rxs` in 1: asynchronous serial line; idles high.
- `o_rvalid` out 1: holding register contains a word.
- `i_rready` in 1: consumer accepts the word when `o_rvalid && i_rready`.
- `o_rdata` out DLEN: received word; bit 0 is the first data bit on the line.
- `o_ferr` out 1: framing error for the held word; qualified by `o_rvalid`.
- `o_perr` out 1: parity error for the held word; qualified by `o_rvalid`.
- `o_overrun` out 1: one-cycle pulse when a completed frame is dropped.

## Operation
- **Synchroniser:** 2-FF, reset to 1. All logic uses the synchronised line `rxs_s`.
- **Tick generator:**
  - `TickDiv = CLKF/(BAUD*OSR)`, integer-truncated.
  - Elaboration `$error` if `TickDiv < 2`.
  - Emits a one-cycle `tick` every `TickDiv` clocks.
  - Restarts at count 0 on the cycle IDLE leaves on a falling edge.
- **Sample counter** `sct` (0..OSR-1): advances on each tick and wraps at OSR-1. A wrap marks the end of a bit period.
- **Majority vote:** samples taken at `sct = OSR/2-1, OSR/2, OSR/2+1`. The bit value is the 2-of-3 majority, decided on the tick where `sct = OSR/2+1`.
- **States** (`rx_state_e`): IDLE, START, DATA, PARITY, STOP.
  - **IDLE:** on `rxs_s` 1→0, go to START with `sct = 0` and `bit_idx = 0`.
  - **START:** if the vote is 1, this is a false start; return to IDLE with no output. If the vote is 0, go to DATA at the `sct` wrap.
  - **DATA:** each vote is shifted in LSB-first. After bit `DLEN-1` is voted, go to PARITY at the wrap if parity is compiled in, otherwise to STOP.
  - **PARITY:** vote the parity bit. Go to STOP at the wrap.
  - **STOP:** vote each stop bit. `ferr` is the OR of (vote == 0) over all stop bits. On the final stop-bit vote, commit the frame and go directly to IDLE without waiting for the wrap, so the next start edge can be detected half a bit early.
- **Commit:**
  - If `o_rvalid && !i_rready`: drop the frame, pulse `o_overrun`, and leave the held word and its flags unchanged.
  - Otherwise: load `o_rdata`, `o_ferr` and `o_perr`, and set `o_rvalid = 1`.
  - Frames with `ferr` or `perr` set are still delivered.
- **Simultaneous handshake and commit:** `o_rvalid && i_rready` on the commit cycle loads the new word and keeps `o_rvalid` high. No overrun is flagged.
- **Handshake without commit:** `o_rvalid && i_rready` clears `o_rvalid` on the next edge.
- **Reset mid-frame:** the frame is aborted with no output. The state returns to IDLE.

## Timing
- Reset values:
  - `o_rvalid = 0`, `o_rdata = 0`, `o_ferr = 0`, `o_perr = 0`, `o_overrun = 0`.
  - State is IDLE; synchroniser flops are 1.
- Edge detection lags the pin by 2 clocks (synchroniser) plus 1 clock (edge register).
- `o_rvalid` and `o_overrun` assert on the clock after the tick carrying the final stop-bit vote.
- Minimum spacing between commits: one full frame, i.e. `(1+DLEN+P+STOP_BITS)*OSR*TickDiv` clocks, where P = 1 if parity is compiled in, else 0.

## Configuration
- Macro: `UART_RX_PARITY_EN`.
- **Defined:**
  - The PARITY state exists.
  - `perr` = vote XOR (^data) XOR `PARITY_ODD`.
  - `o_perr` is registered at commit.
- **Undefined:**
  - No PARITY state; DATA goes directly to STOP.
  - `o_perr` is tied to 0.
  - `PARITY_ODD` is ignored.

## Structure
- Package `uart_pkg` contains:
  - the `rx_state_e` enum;
  - `localparam` helpers for `TickDiv` computation;
  - a `maj3` function.
- Sub-module `uart_baud_tick`: parametrised tick divider with a synchronous restart input. It is shared with the planned TX successor.

## Test plan
Bench parameters: `CLKF = 100 MHz`, `BAUD = 625000`, `OSR = 16`, so `TickDiv = 10` and 160 clocks per bit.
1. **Basic receive:** send 0xA5 in 8N1 with `i_rready = 1` → one `o_rvalid` pulse, `o_rdata = 0xA5`, `ferr = perr = 0`.
2. **Back-pressure and overrun:** send 0x3C then 0xC3 back-to-back with `i_rready = 0` → `o_rdata` holds 0x3C, `o_overrun` pulses once at the second commit. Raise `i_rready` → `o_rvalid` deasserts.
3. **False start:** 40-clock low glitch on an idle line → state returns to IDLE, no `o_rvalid`. Then send 0x55 → received correctly.
4. **Framing error:** stop bit driven low for frame 0x0F → `o_rdata = 0x0F`, `o_ferr = 1`. Frame 0x10 immediately after → `o_ferr = 0`.
5. **Parity (`UART_RX_PARITY_EN` defined, `PARITY_ODD = 0`, `DLEN = 7`):**
   - 0x41 with parity bit 0 → `perr = 0`.
   - 0x41 with parity bit 1 → `perr = 1`.
6. **Mid-frame reset and noise rejection:** assert `rstn` low during bit 4 → all outputs return to reset values and no word is delivered. Then send 0x81 with a 1-sample-wide inverted glitch at every bit centre → `o_rdata = 0x81`.
